// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master / two-slave bus arbiter:
// FSM encodings, master indices and the default slave address map.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT_M0 = 2'b01,
        GRANT_M1 = 2'b10
    } arb_state_t;

    localparam logic MASTER_M0 = 1'b0;
    localparam logic MASTER_M1 = 1'b1;

    localparam logic [7:0] S0_BASE_DEFAULT = 8'h00;
    localparam logic [7:0] S0_TOP_DEFAULT  = 8'h07;
    localparam logic [7:0] S1_BASE_DEFAULT = 8'h10;
    localparam logic [7:0] S1_TOP_DEFAULT  = 8'h3F;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: flags which slave window (inclusive bounds)
// an 8-bit bus address falls into.
module bus_addr_decoder
    import bus_arbiter_pkg::*;
#(
    parameter logic [7:0] S0_BASE = S0_BASE_DEFAULT,
    parameter logic [7:0] S0_TOP  = S0_TOP_DEFAULT,
    parameter logic [7:0] S1_BASE = S1_BASE_DEFAULT,
    parameter logic [7:0] S1_TOP  = S1_TOP_DEFAULT
) (
    input  logic [7:0] address,
    output logic       s0_hit,
    output logic       s1_hit
);

    logic [7:0] s0_offset;
    logic [7:0] s1_offset;

    // Offset-from-base compare keeps a single unsigned test per window,
    // which also stays correct when a base sits at address zero.
    assign s0_offset = address - S0_BASE;
    assign s1_offset = address - S1_BASE;

    assign s0_hit = (s0_offset <= (S0_TOP - S0_BASE));
    assign s1_hit = (s1_offset <= (S1_TOP - S1_BASE));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with grant hold for the shared DMA memory bus; muxes the
// granted master onto the slaves and returns registered-select read data.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter logic [7:0] S0_BASE = S0_BASE_DEFAULT,
    parameter logic [7:0] S0_TOP  = S0_TOP_DEFAULT,
    parameter logic [7:0] S1_BASE = S1_BASE_DEFAULT,
    parameter logic [7:0] S1_TOP  = S1_TOP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        M0_req,
    input  logic        M0_wr,
    input  logic [7:0]  M0_address,
    input  logic [31:0] M0_dout,
    output logic        M0_grant,
    input  logic        M1_req,
    input  logic        M1_wr,
    input  logic [7:0]  M1_address,
    input  logic [31:0] M1_dout,
    output logic        M1_grant,
    output logic [31:0] M_din,
    output logic        S0_sel,
    output logic        S1_sel,
    output logic        S_wr,
    output logic [7:0]  S_address,
    output logic [31:0] S_din,
    input  logic [31:0] S0_dout,
    input  logic [31:0] S1_dout,
    output logic        bus_err
);

    arb_state_t state;
    arb_state_t next_state;
    logic       last_grant;
    logic       granted;
    logic       raw_wr;
    logic       s0_hit;
    logic       s1_hit;
    logic [1:0] rsel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= MASTER_M1;
            rsel       <= 2'b00;
            bus_err    <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == GRANT_M0) begin
                last_grant <= MASTER_M0;
            end else if (next_state == GRANT_M1) begin
                last_grant <= MASTER_M1;
            end
            rsel    <= {S1_sel, S0_sel} & {2{~S_wr}};
            bus_err <= granted & ~(s0_hit | s1_hit);
        end
    end

    // No preemption: an owner keeps the bus until it drops its request.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (M0_req && M1_req) begin
                    next_state = (last_grant == MASTER_M1) ? GRANT_M0 : GRANT_M1;
                end else if (M0_req) begin
                    next_state = GRANT_M0;
                end else if (M1_req) begin
                    next_state = GRANT_M1;
                end
            end
            GRANT_M0: begin
                if (!M0_req) begin
                    next_state = M1_req ? GRANT_M1 : IDLE;
                end
            end
            GRANT_M1: begin
                if (!M1_req) begin
                    next_state = M0_req ? GRANT_M0 : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        M0_grant  = 1'b0;
        M1_grant  = 1'b0;
        raw_wr    = 1'b0;
        S_address = 8'h00;
        S_din     = 32'h0;
        case (state)
            GRANT_M0: begin
                M0_grant  = 1'b1;
                raw_wr    = M0_wr;
                S_address = M0_address;
                S_din     = M0_dout;
            end
            GRANT_M1: begin
                M1_grant  = 1'b1;
                raw_wr    = M1_wr;
                S_address = M1_address;
                S_din     = M1_dout;
            end
            default: ;
        endcase
    end

    assign granted = (state != IDLE);

    bus_addr_decoder #(
        .S0_BASE(S0_BASE),
        .S0_TOP (S0_TOP),
        .S1_BASE(S1_BASE),
        .S1_TOP (S1_TOP)
    ) u_decoder (
        .address(S_address),
        .s0_hit (s0_hit),
        .s1_hit (s1_hit)
    );

    // Writes to unmapped space are dropped rather than reaching any slave.
    assign S0_sel = granted & s0_hit;
    assign S1_sel = granted & s1_hit;
    assign S_wr   = raw_wr & (S0_sel | S1_sel);

    always_comb begin
        M_din = 32'h0;
        case (rsel)
            2'b01:   M_din = S0_dout;
            2'b10:   M_din = S1_dout;
            default: M_din = 32'h0;
        endcase
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, two-slave shared-bus controller for the DMA subsystem.
- Arbitrates the single memory bus between M0 (testbench/CPU port) and M1 (DMA master) using round-robin with grant hold.
- Decodes the granted address into slave selects, muxes write-side signals to slaves, and returns registered-select read data to both masters.

Parameters:
- S0_BASE, 8'h00, first address of slave 0 (DMA register block).
- S0_TOP, 8'h07, last address of slave 0 (inclusive).
- S1_BASE, 8'h10, first address of slave 1 (data memory).
- S1_TOP, 8'h3F, last address of slave 1 (inclusive).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- M0_req  in  1  master 0 bus request.
- M0_wr  in  1  master 0 write strobe.
- M0_address  in  8  master 0 address.
- M0_dout  in  32  master 0 write data.
- M0_grant  out  1  master 0 owns the bus.
- M1_req, M1_wr, M1_address, M1_dout, M1_grant  as M0, for master 1.
- M_din  out  32  read data returned to both masters.
- S0_sel  out  1  slave 0 select.
- S1_sel  out  1  slave 1 select.
- S_wr  out  1  write strobe to slaves.
- S_address  out  8  address to slaves.
- S_din  out  32  write data to slaves.
- S0_dout  in  32  slave 0 read data, valid the cycle after the select.
- S1_dout  in  32  slave 1 read data, valid the cycle after the select.
- bus_err  out  1  one-cycle pulse on granted access to an unmapped address.

Behaviour:
- Reset values:
  - Grants, selects, S_wr and bus_err are 0.
  - S_address, S_din and M_din are 0.
  - State is IDLE; last_grant is M1, so M0 wins the first tie.
- FSM states: IDLE, GRANT_M0, GRANT_M1. Grants are Moore outputs (GRANT_Mx implies Mx_grant=1).
- IDLE:
  - Only M0_req -> GRANT_M0.
  - Only M1_req -> GRANT_M1.
  - Both -> grant the master that is not last_grant.
  - Neither -> stay in IDLE.
- GRANT_Mx:
  - Hold while Mx_req=1. There is no preemption; a DMA transfer keeps the bus for its whole burst.
  - When Mx_req=0 and the other master is requesting -> go directly to the other grant, no idle cycle.
  - When Mx_req=0 and the other master is not requesting -> IDLE.
- last_grant updates on every entry into a GRANT state.
- Latency: a req sampled high at edge k in IDLE gives grant high after edge k. Release: req low at edge k gives grant low after edge k.
- Write/address mux (combinational from state):
  - GRANT_Mx: S_address, S_wr and S_din follow the Mx signals.
  - IDLE: all forced to 0.
- Decode (combinational):
  - S0_sel=1 when the bus is granted and S0_BASE<=S_address<=S0_TOP.
  - S1_sel=1 when the bus is granted and S1_BASE<=S_address<=S1_TOP.
  - Both ranges are inclusive and must not overlap. At most one select is ever high.
  - Unmapped address: both selects 0 and S_wr forced to 0, so the write is dropped.
- Read return:
  - A registered read-select (2 bits) captures {S1_sel, S0_sel} & ~S_wr at each edge.
  - M_din = S0_dout if rsel[0], S1_dout if rsel[1], else 32'h0.
  - Read data is therefore valid exactly one cycle after the address.
  - The registered select clears on a write or idle cycle.
- bus_err is registered: high for one cycle after any granted cycle whose address decodes to no slave.
- Grant switch: the read-select of the old master's last read cycle still returns data in the first cycle of the new grant. The receiving master ignores it unless it issued the read.
- Asynchronous reset mid-transfer: grants, selects and read-select drop immediately, with no completion of an in-flight write.

Decomposition:
- Shared package:
  - State encodings IDLE=2'b00, GRANT_M0=2'b01, GRANT_M1=2'b10.
  - Master index constants.
  - Default address-map constants, also used by the top-level and bench.
- One natural sub-module: bus_addr_decoder (combinational address-to-select, parameterised by the four range bounds), instantiated once.

Test Plan:
- Reset, then M0_req=1 alone -> M0_grant=1 next cycle. M0 write 32'hDEADBEEF to 8'h12 -> S1_sel=1, S_wr=1, S_din=32'hDEADBEEF.
- M0_req and M1_req rise in the same cycle after reset -> M0 granted. M0 drops its req -> M1_grant=1 the next cycle with no IDLE gap. Both then re-request -> M0 wins (round-robin).
- M1 reads 8'h03 while S0_dout=32'h0000_0005 in the following cycle -> M_din=32'h5 exactly one cycle after the address. A write cycle that follows returns M_din=0.
- M1 holds its req for an 8-beat read/write burst while M0 requests -> M0_grant stays 0 for the whole burst and rises the cycle after M1_req falls.
- Granted write to 8'h09 (unmapped) -> S0_sel=S1_sel=0, S_wr=0, and bus_err pulses for exactly 1 cycle.
- Assert reset_n=0 mid-burst while M1 is granted -> M1_grant, S1_sel and S_wr go to 0 immediately. After release, a new tie is granted to M0.
